// File: rtl/scpu_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the SCPU program loader.
// The loader uses the slave modport; the host/memory side uses master.
interface scpu_program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ins_index;
  logic              ins_we;
  logic [15:0]       instructs;

  modport master (
    output in_valid, in_data,
    input  in_ready, ins_index, ins_we, instructs
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ins_index, ins_we, instructs
  );
endinterface

// File: rtl/scpu_program_loader.sv
// Loads big-endian 16-bit instructions from a byte stream into SCPU memory, then sequences fetch.
// Define SCPU_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (mismatch -> ERR).
module scpu_program_loader #(
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  scpu_program_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       word;
  logic [DC_W-1:0]   drain_cnt;
  logic              last_idx;
`ifdef SCPU_LOADER_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  // idx is the write pointer while loading and the fetch counter while running;
  // len=0 makes len-1 the all-ones address, giving the full 2**ADDR_W wrap.
  assign last_idx      = (idx == len - ADDR_W'(1));
  assign bus.in_ready  = (state == S_LEN) || (state == S_HI) || (state == S_LO) || (state == S_CHK);
  assign bus.ins_index = idx;
  assign bus.instructs = word;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.ins_we = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        busy = 1'b0;
        done = (state == S_DONE);
`ifdef SCPU_LOADER_CHECKSUM_EN
        err  = (state == S_ERR);
`endif
        if (start) state_nxt = S_LEN;
      end
      S_LEN:   if (bus.in_valid) state_nxt = S_HI;
      S_HI:    if (bus.in_valid) state_nxt = S_LO;
      S_LO:    if (bus.in_valid) state_nxt = S_WR;
      S_WR: begin
        bus.ins_we = 1'b1;
        if (last_idx) begin
`ifdef SCPU_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_RUN;
`endif
        end else begin
          state_nxt = S_HI;
        end
      end
`ifdef SCPU_LOADER_CHECKSUM_EN
      S_CHK: if (bus.in_valid) state_nxt = (bus.in_data == chk_acc) ? S_RUN : S_ERR;
`endif
      S_RUN:   if (last_idx) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DC_W'(DRAIN_CYC - 1)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      idx       <= '0;
      word      <= '0;
      drain_cnt <= '0;
`ifdef SCPU_LOADER_CHECKSUM_EN
      chk_acc   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            idx       <= '0;
            drain_cnt <= '0;
          end
        end
        S_LEN: begin
          if (bus.in_valid) begin
            len <= ADDR_W'(bus.in_data);
`ifdef SCPU_LOADER_CHECKSUM_EN
            chk_acc <= bus.in_data;
`endif
          end
        end
        S_HI: begin
          if (bus.in_valid) begin
            word[15:8] <= bus.in_data;
`ifdef SCPU_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ bus.in_data;
`endif
          end
        end
        S_LO: begin
          if (bus.in_valid) begin
            word[7:0] <= bus.in_data;
`ifdef SCPU_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ bus.in_data;
`endif
          end
        end
        // After the final write the pointer restarts at 0 to become the fetch counter.
        S_WR:    idx <= last_idx ? '0 : idx + ADDR_W'(1);
        S_RUN: begin
          drain_cnt <= '0;
          if (!last_idx) idx <= idx + ADDR_W'(1);
        end
        S_DRAIN: drain_cnt <= drain_cnt + DC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scpu_program_loader.sv
// Self-checking bench for scpu_program_loader: a stream-level model predicts every memory write
// and every fetch/drain address; a compare process checks them each cycle.
module tb_scpu_program_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err;

  scpu_program_loader_if #(.ADDR_W(8)) lb ();

  scpu_program_loader #(.ADDR_W(8), .DRAIN_CYC(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (lb.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         wr_seen = 0;
  int         fetch_seen = 0;
  logic [7:0] stim[$];
  wr_t        exp_wr[$];
  logic [7:0] exp_fetch[$];
  wr_t        cmp_w;
  logic [7:0] cmp_a;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writes and fetch/drain cycles are recognised from outputs alone and checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (lb.ins_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL unexpected_write: got write idx %0h data %0h expected none", lb.ins_index, lb.instructs);
        end else begin
          cmp_w = exp_wr.pop_front();
          checkOutput("wr_addr", lb.ins_index, cmp_w.addr);
          checkOutput("wr_data", lb.instructs, cmp_w.data);
        end
      end else if (busy && !lb.in_ready) begin
        fetch_seen++;
        if (exp_fetch.size() == 0) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL unexpected_fetch: got busy cycle idx %0h expected none", lb.ins_index);
        end else begin
          cmp_a = exp_fetch.pop_front();
          checkOutput("fetch_idx", lb.ins_index, cmp_a);
        end
      end
    end
  end

  function automatic logic [7:0] stim_xor();
    logic [7:0] x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    return x;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_lo);
    int guard = 0;
    bit acc = 1'b0;
    lb.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    lb.in_valid = 1'b1;
    lb.in_data  = b;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = lb.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    lb.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL byte_accept: got no in_ready expected accept of %02h", b);
    end else if (is_lo) begin
      checkOutput("word_latency_we", lb.ins_we, 1);
    end
  endtask

  // Full load of stim (length byte + instruction bytes); model expectations are built first.
  task automatic applyStimulus(input int max_gap, input bit chk_good);
    int  n;
    wr_t w;
    wr_seen    = 0;
    fetch_seen = 0;
    exp_wr.delete();
    exp_fetch.delete();
    n = (stim[0] == 8'h00) ? 256 : int'(stim[0]);
    for (int i = 0; i < n; i++) begin
      w.addr = 8'(i);
      w.data = {stim[1 + 2*i], stim[2 + 2*i]};
      exp_wr.push_back(w);
    end
    if (chk_good) begin
      for (int i = 0; i < n; i++) exp_fetch.push_back(8'(i));
      repeat (4) exp_fetch.push_back(8'(n - 1));
    end
    do_start();
    checkOutput("start_clears_err", err, 0);
    checkOutput("start_sets_busy", busy, 1);
    foreach (stim[k])
      send_byte(stim[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, (k > 0) && (k % 2 == 0));
`ifdef SCPU_LOADER_CHECKSUM_EN
    send_byte(chk_good ? stim_xor() : 8'h00, 0, 1'b0);
`endif
    for (int i = 0; i < 3000 && !(done || err); i++) @(negedge clk);
    checkOutput("done", done, chk_good);
    checkOutput("err", err, !chk_good);
    checkOutput("busy_end", busy, 0);
    checkOutput("writes_left", exp_wr.size(), 0);
    checkOutput("fetch_left", exp_fetch.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    lb.in_valid = 1'b1;
    lb.in_data  = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] test 1: reset values");
    checkOutput("rst_in_ready", lb.in_ready, 0);
    checkOutput("rst_ins_index", lb.ins_index, 0);
    checkOutput("rst_ins_we", lb.ins_we, 0);
    checkOutput("rst_instructs", lb.instructs, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    @(posedge clk); #1;
    checkOutput("idle_in_ready", lb.in_ready, 0);
    lb.in_valid = 1'b0;

    $display("[TB] test 2: two-word program");
    stim = '{8'h02, 8'h10, 8'hAB, 8'h20, 8'hCD};
    applyStimulus(0, 1'b1);
    checkOutput("t2_writes", wr_seen, 2);
    checkOutput("t2_fetch_drain_cycles", fetch_seen, 6);
    checkOutput("t2_last_word", lb.instructs, 16'h20CD);
    checkOutput("t2_done_idx", lb.ins_index, 8'h01);

    $display("[TB] test 3: gapped stream");
    applyStimulus(3, 1'b1);
    checkOutput("t3_writes", wr_seen, 2);

    $display("[TB] test 4: L=0 full wrap");
    stim = '{8'h00};
    for (int i = 0; i < 512; i++) stim.push_back(8'(i * 7 + 3));
    applyStimulus(0, 1'b1);
    checkOutput("t4_writes", wr_seen, 256);
    checkOutput("t4_fetch_drain_cycles", fetch_seen, 260);
    checkOutput("t4_done_idx", lb.ins_index, 8'hFF);

    $display("[TB] test 5: reset mid-word");
    exp_wr.delete();
    exp_fetch.delete();
    wr_seen = 0;
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_in_ready", lb.in_ready, 0);
    checkOutput("t5_instructs", lb.instructs, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5_no_write", wr_seen, 0);
    stim = '{8'h02, 8'h10, 8'hAB, 8'h20, 8'hCD};
    applyStimulus(0, 1'b1);
    checkOutput("t5_reload_writes", wr_seen, 2);

`ifdef SCPU_LOADER_CHECKSUM_EN
    $display("[TB] test 6: checksum");
    stim = '{8'h01, 8'h12, 8'h34};
    applyStimulus(0, 1'b1);
    checkOutput("t6_good_fetch", fetch_seen, 5);
    applyStimulus(0, 1'b0);
    checkOutput("t6_bad_no_run", fetch_seen, 0);
    applyStimulus(0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
